// File: rtl/seg_scan_driver_if.sv
// Digit-input / display-output bundle for seg_scan_driver.
// blink_mask exists only when SEG_SCAN_BLINK_EN is defined.
interface seg_scan_driver_if #(
   parameter int NUM_DIGITS = 6
);
   logic [4*NUM_DIGITS-1:0] digits_in;
   logic [NUM_DIGITS-1:0]   dp_in;
   logic                    blank_lz;
`ifdef SEG_SCAN_BLINK_EN
   logic [NUM_DIGITS-1:0]   blink_mask;
`endif
   logic [6:0]              seg_out;
   logic                    dp_out;
   logic [NUM_DIGITS-1:0]   dig_sel;
   logic                    frame_start;

`ifdef SEG_SCAN_BLINK_EN
   modport master (output digits_in, dp_in, blank_lz, blink_mask,
                   input  seg_out, dp_out, dig_sel, frame_start);
   modport slave  (input  digits_in, dp_in, blank_lz, blink_mask,
                   output seg_out, dp_out, dig_sel, frame_start);
`else
   modport master (output digits_in, dp_in, blank_lz,
                   input  seg_out, dp_out, dig_sel, frame_start);
   modport slave  (input  digits_in, dp_in, blank_lz,
                   output seg_out, dp_out, dig_sel, frame_start);
`endif
endinterface

// File: rtl/seg_scan_driver.sv
// Multiplexed seven-segment scanner with per-frame input snapshot and leading-zero blanking.
// Define SEG_SCAN_BLINK_EN to add per-digit blinking (blink_mask, BLINK_FRAMES).
module seg_scan_driver #(
   parameter int NUM_DIGITS     = 6,
   parameter int SCAN_DIV       = 50000,
   parameter int GUARD          = 2,
   parameter bit SEG_ACTIVE_LOW = 1'b1,
   parameter bit DIG_ACTIVE_LOW = 1'b1
`ifdef SEG_SCAN_BLINK_EN
   , parameter int BLINK_FRAMES = 32
`endif
) (
   input logic              clk,
   input logic              rst,
   seg_scan_driver_if.slave bus
);
   localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [6:0]            SEG_OFF = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;
   localparam logic                  DP_OFF  = SEG_ACTIVE_LOW;
   localparam logic [NUM_DIGITS-1:0] DIG_OFF = DIG_ACTIVE_LOW ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

   logic [PW-1:0]              presc_q, presc_d;
   logic [IW-1:0]              idx_q, idx_d;
   logic [NUM_DIGITS-1:0][3:0] digits_q, digits_d;
   logic [NUM_DIGITS-1:0]      dp_q, dp_d;
   logic [6:0]                 seg_q, seg_d;
   logic                       dpo_q, dpo_d;
   logic [NUM_DIGITS-1:0]      dig_q, dig_d;
   logic                       fs_q, fs_d;

   logic                  tick, wrap, in_guard, blink_off, blank, upper_zero;
   logic [NUM_DIGITS-1:0] lz_blank;
   logic [3:0]            cur;
   logic [6:0]            seg_on;

   function automatic logic [6:0] decode(input logic [3:0] v);
      case (v)
         4'd0:    decode = 7'h3F;
         4'd1:    decode = 7'h06;
         4'd2:    decode = 7'h5B;
         4'd3:    decode = 7'h4F;
         4'd4:    decode = 7'h66;
         4'd5:    decode = 7'h6D;
         4'd6:    decode = 7'h7D;
         4'd7:    decode = 7'h07;
         4'd8:    decode = 7'h7F;
         4'd9:    decode = 7'h6F;
         default: decode = 7'h00;
      endcase
   endfunction

   assign tick = (presc_q == PW'(SCAN_DIV - 1));
   assign wrap = tick && (idx_q == IW'(NUM_DIGITS - 1));

   generate
      if (GUARD == 0) begin : g_noguard
         assign in_guard = 1'b0;
      end else begin : g_guard
         assign in_guard = (presc_q < PW'(GUARD));
      end
   endgenerate

`ifdef SEG_SCAN_BLINK_EN
   localparam int BW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   logic [BW-1:0]         bcnt_q, bcnt_d;
   logic                  phase_q, phase_d;   // 1 = blinking digits dark
   logic [NUM_DIGITS-1:0] mask_q, mask_d;

   always_comb begin
      bcnt_d  = bcnt_q;
      phase_d = phase_q;
      mask_d  = mask_q;
      if (wrap) begin
         mask_d = bus.blink_mask;
         if (bcnt_q == BW'(BLINK_FRAMES - 1)) begin
            bcnt_d  = '0;
            phase_d = ~phase_q;
         end else begin
            bcnt_d = bcnt_q + BW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bcnt_q  <= '0;
         phase_q <= 1'b0;
         mask_q  <= '0;
      end else begin
         bcnt_q  <= bcnt_d;
         phase_q <= phase_d;
         mask_q  <= mask_d;
      end
   end

   assign blink_off = phase_q & mask_q[idx_q];
`else
   assign blink_off = 1'b0;
`endif

   // Scan counters and the frame snapshot, which only moves on the wrap tick.
   always_comb begin
      presc_d  = tick ? '0 : presc_q + PW'(1);
      idx_d    = idx_q;
      if (tick) idx_d = wrap ? '0 : idx_q + IW'(1);
      digits_d = digits_q;
      dp_d     = dp_q;
      if (wrap) begin
         digits_d = bus.digits_in;
         dp_d     = bus.dp_in;
      end
      fs_d = wrap;
   end

   // A digit is a leading zero when it and every more significant digit are zero.
   always_comb begin
      upper_zero = 1'b1;
      lz_blank   = '0;
      for (int i = NUM_DIGITS - 1; i > 0; i--) begin
         upper_zero  = upper_zero & (digits_q[i] == 4'h0);
         lz_blank[i] = upper_zero;
      end
   end

   always_comb begin
      cur    = digits_q[idx_q];
      blank  = (bus.blank_lz & lz_blank[idx_q]) | blink_off;
      seg_on = blank ? 7'h00 : decode(cur);
      seg_d  = SEG_OFF;
      dpo_d  = DP_OFF;
      dig_d  = DIG_OFF;
      if (!in_guard) begin
         seg_d = SEG_ACTIVE_LOW ? ~seg_on : seg_on;
         dpo_d = (dp_q[idx_q] & ~blank) ^ SEG_ACTIVE_LOW;
         dig_d = (NUM_DIGITS'(1) << idx_q) ^ DIG_OFF;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         presc_q  <= '0;
         idx_q    <= '0;
         digits_q <= '0;
         dp_q     <= '0;
         seg_q    <= SEG_OFF;
         dpo_q    <= DP_OFF;
         dig_q    <= DIG_OFF;
         fs_q     <= 1'b0;
      end else begin
         presc_q  <= presc_d;
         idx_q    <= idx_d;
         digits_q <= digits_d;
         dp_q     <= dp_d;
         seg_q    <= seg_d;
         dpo_q    <= dpo_d;
         dig_q    <= dig_d;
         fs_q     <= fs_d;
      end
   end

   assign bus.seg_out     = seg_q;
   assign bus.dp_out      = dpo_q;
   assign bus.dig_sel     = dig_q;
   assign bus.frame_start = fs_q;
endmodule
